// File: rtl/sdrd_pkg.sv
// sdrd_pkg: shared FSM state, resync code and serial-space address decode for sdrd_deser.
package sdrd_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_HI} state_t;
    localparam logic [3:0] RESYNC_CODE = 4'hF;
    localparam logic SER_BA13 = 1'b0;
    localparam logic SER_BA12 = 1'b1;
endpackage

// File: rtl/sdrd_deser_sync_edge.sv
// sync_edge: multi-flop synchroniser with falling-edge detect on the synchronised value.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic s,
    output logic fall
);
    logic [STAGES-1:0] d;
    logic              prev;
    logic [STAGES:0]   v;
    // v tracks which samples came from the pin rather than from reset, so a
    // strobe already low at reset release is not mistaken for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '1;
            prev <= 1'b1;
            v    <= '0;
        end else begin
            d[0] <= a;
            for (int i = 1; i < STAGES; i++) d[i] <= d[i-1];
            prev <= d[STAGES-1];
            v    <= {v[STAGES-1:0], 1'b1};
        end
    end
    assign s    = d[STAGES-1];
    assign fall = v[STAGES] & prev & ~d[STAGES-1];
endmodule

// File: rtl/sdrd_deser.sv
// sdrd_deser: assembles serial sdrd bits, one per qualified bus read, into WIDTH-bit words.
module sdrd_deser
    import sdrd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bus_strb_n,
    input  logic                     sser,
    input  logic [9:0]               ba,
    input  logic                     br_w,
    input  logic                     sdrd,
    output logic [WIDTH-1:0]         word,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     overrun,
    output logic [$clog2(WIDTH):0]   bit_cnt
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t                 state;
    logic                   strb_s, strb_fall, sdrd_s, qual, last;
    logic [SYNC_STAGES-1:0] sd;
    logic [WIDTH-1:0]       sh, sh_nxt;

    sync_edge #(.STAGES(SYNC_STAGES)) u_strb (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (bus_strb_n),
        .s    (strb_s),
        .fall (strb_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd <= '1;
        end else begin
            sd[0] <= sdrd;
            for (int i = 1; i < SYNC_STAGES; i++) sd[i] <= sd[i-1];
        end
    end
    assign sdrd_s = sd[SYNC_STAGES-1];

    assign qual = ~sser & (ba[9] == SER_BA13) & (ba[8] == SER_BA12) & br_w;
    assign last = bit_cnt == CW'(WIDTH - 1);

    always_comb begin
        sh_nxt = sh;
        for (int i = 0; i < WIDTH; i++) sh_nxt[i] = (CW'(i) == bit_cnt) ? sdrd_s : sh[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sh         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_valid && word_ready) word_valid <= 1'b0;
            case (state)
                IDLE: if (strb_fall) begin
                    if (qual && ba[3:0] == RESYNC_CODE) begin
                        bit_cnt <= '0;
                        sh      <= '0;
                        state   <= WAIT_HI;
                    end else begin
                        state <= qual ? CAPTURE : WAIT_HI;
                    end
                end
                CAPTURE: begin
                    state <= WAIT_HI;
                    if (last) begin
                        word       <= sh_nxt;
                        word_valid <= 1'b1;
                        sh         <= '0;
                        bit_cnt    <= '0;
                        if (word_valid && !word_ready) overrun <= 1'b1;
                    end else begin
                        sh      <= sh_nxt;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WAIT_HI: if (strb_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdrd_deser.sv
// tb_sdrd_deser: directed self-checking bench for sdrd_deser.
module tb_sdrd_deser;
    logic       clk = 0, rst_n = 0, bus_strb_n = 1, sser = 1, br_w = 1, sdrd = 1, word_ready = 0;
    logic [9:0] ba = '0;
    logic [7:0] word;
    logic       word_valid, overrun;
    logic [3:0] bit_cnt;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    sdrd_deser #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_strb_n(bus_strb_n),
        .sser      (sser),
        .ba        (ba),
        .br_w      (br_w),
        .sdrd      (sdrd),
        .word      (word),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [9:0] a, input logic s, input logic rw, input logic b, input int hold);
        @(negedge clk);
        ba = a; sser = s; br_w = rw; sdrd = b; bus_strb_n = 0;
        cyc(hold);
        bus_strb_n = 1;
        cyc(6);
        sser = 1; sdrd = 1;
    endtask

    task automatic rd_word(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rd(10'h101, 0, 1, v[i], 6);
    endtask

    task automatic consume();
        @(negedge clk); word_ready = 1;
        @(negedge clk); word_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; cyc(2);
        checks++; if (word !== 8'h00) begin errors++; $display("FAIL reset_word: got %h expected 00", word); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bitcnt: got %0d expected 0", bit_cnt); end
        rst_n = 1; cyc(2);
    endtask

    task automatic test_word();
        for (int i = 0; i < 3; i++) rd(10'h101, 0, 1, i[0] ? 1'b0 : 1'b1, 6);
        checks++; if (bit_cnt !== 4'd3) begin errors++; $display("FAIL word_partial_cnt: got %0d expected 3", bit_cnt); end
        for (int i = 3; i < 8; i++) rd(10'h101, 0, 1, (i == 3 || i == 6) ? 1'b1 : 1'b0, 6);
        checks++; if (word !== 8'h4D) begin errors++; $display("FAIL word_value: got %h expected 4d", word); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL word_valid: got %b expected 1", word_valid); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL word_cnt_wrap: got %0d expected 0", bit_cnt); end
        consume();
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL word_consumed: got %b expected 0", word_valid); end
        checks++; if (word !== 8'h4D) begin errors++; $display("FAIL word_held: got %h expected 4d", word); end
    endtask

    task automatic test_filter();
        logic [7:0] v;
        v = 8'h4D;
        for (int i = 0; i < 8; i++) begin
            rd(10'h101, 0, 1, v[i], 6);
            rd(10'h101, 1, 1, ~v[i], 6);
            rd(10'h101, 0, 0, ~v[i], 6);
            rd(10'h001, 0, 1, ~v[i], 6);
            checks++;
            if (bit_cnt !== 4'((i + 1) % 8)) begin
                errors++; $display("FAIL filter_cnt%0d: got %0d expected %0d", i, bit_cnt, (i + 1) % 8);
            end
        end
        checks++; if (word !== 8'h4D) begin errors++; $display("FAIL filter_word: got %h expected 4d", word); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL filter_valid: got %b expected 1", word_valid); end
        consume();
    endtask

    task automatic test_resync();
        rd(10'h101, 0, 1, 1'b0, 6);
        rd(10'h101, 0, 1, 1'b1, 6);
        rd(10'h101, 0, 1, 1'b0, 6);
        checks++; if (bit_cnt !== 4'd3) begin errors++; $display("FAIL resync_pre_cnt: got %0d expected 3", bit_cnt); end
        rd(10'h10F, 0, 1, 1'b1, 6);
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL resync_cnt: got %0d expected 0", bit_cnt); end
        checks++; if (word_valid !== 1'b0 || word !== 8'h4D) begin
            errors++; $display("FAIL resync_word: got %b/%h expected 0/4d", word_valid, word);
        end
        rd_word(8'hFF);
        checks++; if (word !== 8'hFF) begin errors++; $display("FAIL resync_word_ff: got %h expected ff", word); end
        consume();
    endtask

    task automatic test_long_strobe();
        rd(10'h101, 0, 1, 1'b1, 20);
        checks++; if (bit_cnt !== 4'd1) begin errors++; $display("FAIL long_strobe_cnt: got %0d expected 1", bit_cnt); end
        rd(10'h10F, 0, 1, 1'b1, 6);
    endtask

    task automatic test_overrun();
        rd_word(8'h4D);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", overrun); end
        rd_word(8'hA5);
        checks++; if (word !== 8'hA5) begin errors++; $display("FAIL overrun_word: got %h expected a5", word); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", word_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
        consume();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid();
        rd_word(8'h4D);
        for (int i = 0; i < 5; i++) rd(10'h101, 0, 1, 1'b1, 6);
        checks++; if (bit_cnt !== 4'd5) begin errors++; $display("FAIL rstmid_pre_cnt: got %0d expected 5", bit_cnt); end
        @(posedge clk); #2 rst_n = 0; #1;
        checks++; if (word !== 8'h00 || word_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_word: got %h/%b expected 00/0", word, word_valid);
        end
        checks++; if (bit_cnt !== 4'd0 || overrun !== 1'b0) begin
            errors++; $display("FAIL rstmid_cnt: got %0d/%b expected 0/0", bit_cnt, overrun);
        end
        cyc(2); rst_n = 1; cyc(2);
        rd_word(8'h3C);
        checks++; if (word !== 8'h3C || word_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_next_word: got %h/%b expected 3c/1", word, word_valid);
        end
        consume();
    endtask

    task automatic test_strobe_low_release();
        @(negedge clk);
        rst_n = 0; bus_strb_n = 0; sser = 0; ba = 10'h101; br_w = 1;
        cyc(2); rst_n = 1; cyc(10);
        bus_strb_n = 1; cyc(6); sser = 1;
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL release_no_capture: got %0d expected 0", bit_cnt); end
        rd(10'h101, 0, 1, 1'b1, 6);
        checks++; if (bit_cnt !== 4'd1) begin errors++; $display("FAIL release_first_read: got %0d expected 1", bit_cnt); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_filter();
        test_resync();
        test_long_strobe();
        test_overrun();
        test_reset_mid();
        test_strobe_low_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdrd_deser.md
SDRD_DESER -- requirements
Module: sdrd_deser

Interface
REQ-001 Parameter WIDTH, default 8, word length assembled from serial bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth for bus strobe and sdrd.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 bus_strb_n  input  1  asynchronous bus cycle strobe, active-low.
REQ-006 sser  input  1  serial-space select, active-low.
REQ-007 ba  input  10  bus address BA13..BA4 (ba[9]=BA13, ba[8]=BA12, ba[3:0]=BA7..BA4).
REQ-008 br_w  input  1  bus direction, 1=read.
REQ-009 sdrd  input  1  serial data bit from the sequencer GAL; undriven when not selected (pulled up externally).
REQ-010 word  output  WIDTH  assembled word, LSB first received.
REQ-011 word_valid  output  1  word holds an unconsumed word.
REQ-012 word_ready  input  1  consumer accepts word when high with word_valid.
REQ-013 overrun  output  1  sticky: a word completed while previous unconsumed.
REQ-014 bit_cnt  output  log2(WIDTH)+1  bits collected in current word.

Function
REQ-015 bus_strb_n and sdrd SHALL pass through SYNC_STAGES flops each before use.
REQ-016 Qualified read = synchronised falling edge of bus_strb_n with sser=0, ba[9]=0, ba[8]=1, br_w=1; address/direction sampled in the same cycle the edge is detected.
REQ-017 Qualified read with ba[3:0]=4'hF is a RESYNC: bit_cnt cleared, shift register cleared, no bit captured, word/word_valid untouched.
REQ-018 Any other qualified read SHALL capture synchronised sdrd one clk after the edge detect (latency 1 clk) into shift register at position bit_cnt; bit_cnt increments.
REQ-019 FSM states: IDLE (no strobe active), CAPTURE (one-cycle sample), WAIT_HI (strobe still low; no further capture until synchronised strobe returns high). One capture per bus cycle.
REQ-020 Transitions: IDLE->CAPTURE on qualified edge; CAPTURE->WAIT_HI; WAIT_HI->IDLE on synchronised strobe high; non-qualified edge: IDLE->WAIT_HI.
REQ-021 When bit_cnt reaches WIDTH in CAPTURE: shift register copied to word, word_valid set, bit_cnt wraps to 0 in the same cycle.
REQ-022 word_valid clears on clk with word_valid&word_ready; word held stable while word_valid=1 and unconsumed.
REQ-023 Completion while word_valid=1 and word_ready=0: word overwritten with new value, word_valid stays 1, overrun set.
REQ-024 Completion in same cycle as handshake: new word loaded, word_valid stays 1, no overrun.
REQ-025 overrun clears only on reset.
REQ-026 Writes (br_w=0) and sser=1 cycles SHALL never alter bit_cnt, shift register or word.

Reset
REQ-027 On rst_n low, immediately: FSM=IDLE, bit_cnt=0, shift register=0, word=0, word_valid=0, overrun=0, synchroniser flops=1.
REQ-028 Reset mid-word discards partial bits; first qualified read after release captures bit 0.
REQ-029 Strobe low at reset release SHALL not cause a capture (synchronisers reset high; falling edge requires high-to-low seen after release... FSM enters WAIT_HI only on a later edge).

Structure
REQ-030 Shared package sdrd_pkg holds FSM state enum, RESYNC_CODE=4'hF, serial-space decode constants (BA13=0, BA12=1).
REQ-031 One sub-module, sync_edge, implements SYNC_STAGES synchroniser plus falling-edge detect; instantiated for bus_strb_n; sdrd uses synchroniser only.

Verification
REQ-032 Eight qualified reads, ba=10'h10_1? (BA7..4≠F) with sdrd 1,0,1,1,0,0,1,0 -> word=8'h4D, word_valid=1, bit_cnt=0.
REQ-033 Three bits captured, then qualified read ba[3:0]=4'hF -> bit_cnt=0; next eight bits 8'hFF pattern -> word=8'hFF.
REQ-034 Two full words, word_ready=0 throughout -> word=second value, word_valid=1, overrun=1.
REQ-035 Reads with sser=1, br_w=0, or ba[8]=0 interleaved between valid reads -> bit_cnt unchanged by them, final word identical to REQ-032.
REQ-036 Strobe held low 20 clk during one qualified read -> exactly one bit captured.
REQ-037 rst_n pulsed low mid-clock after 5 bits -> all outputs 0 immediately; next 8 bits form a complete word.
